cpu_ctrl_fsm: RTL and testbench

Parametrised successor of the CPU control state machine: fetches 16-bit instructions, decodes them and drives register-file, ALU-mux, flag, PC and memory controls for the datapath. It adds the following over the previous generation:
- a memory ready handshake, so memories with wait states are supported;
- a configurable number of controller pads;
- coherent link and pad snapshots;
- defined handling of unknown instructions;
- an optional resume-from-halt.

It sits between instruction/data memory port A, the register file, the ALU/flags block and the PC unit.

---
 rtl/cpu_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Control state machine: fetches 16-bit instructions and sequences the register-file, ALU, PC and memory controls.
// Optional feature: define CTRL_RESUME_EN to let the resume input leave STOP.
module cpu_ctrl_fsm #(
    parameter int ADDR_WIDTH = 12,
    parameter int PAD_COUNT  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             mem_in,
    input  logic                    mem_ready,
    input  logic [4:0]              flags,
    input  logic [ADDR_WIDTH-1:0]   pc_ins,
    input  logic [12*PAD_COUNT-1:0] pad_data,
    input  logic                    resume,
    output logic [15:0]             opcode,
    output logic [15:0]             reg_en,
    output logic [3:0]              mux_a_sel,
    output logic [3:0]              mux_b_sel,
    output logic                    alu_sel,
    output logic                    pc_sel,
    output logic                    mem_req,
    output logic                    mem_w_en,
    output logic                    flag_en,
    output logic                    pc_en,
    output logic                    pc_ld,
    output logic                    halted
);

    localparam logic [3:0] S_RESET   = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EXEC    = 4'd3;
    localparam logic [3:0] S_LOAD    = 4'd4;
    localparam logic [3:0] S_LOAD_WB = 4'd5;
    localparam logic [3:0] S_STORE   = 4'd6;
    localparam logic [3:0] S_JUMP    = 4'd7;
    localparam logic [3:0] S_JAL_JMP = 4'd8;
    localparam logic [3:0] S_JAL_LO  = 4'd9;
    localparam logic [3:0] S_JAL_HI  = 4'd10;
    localparam logic [3:0] S_PAD_LO  = 4'd11;
    localparam logic [3:0] S_PAD_HI  = 4'd12;
    localparam logic [3:0] S_STOP    = 4'd13;

    logic [3:0]  state_reg, state_next;
    logic [15:0] ir_reg, ir_next;
    logic [15:0] link_reg, link_next;
    logic [11:0] padsnap_reg, padsnap_next;

    // Channels beyond PAD_COUNT read as zero so any ir[3:0] index is safe.
    logic [11:0] pad_arr [16];
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pad
            if (gi < PAD_COUNT) begin : g_used
                assign pad_arr[gi] = pad_data[12*gi +: 12];
            end else begin : g_unused
                assign pad_arr[gi] = 12'd0;
            end
        end
    endgenerate

`ifndef CTRL_RESUME_EN
    logic unused_resume;
    assign unused_resume = resume;
`endif

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

    // flags = {Z,C,F,N,L}
    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
        logic z, cy, fl, n, l;
        {z, cy, fl, n, l} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return fl;
            4'h9: return !fl;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_next   = state_reg;
        ir_next      = ir_reg;
        link_next    = link_reg;
        padsnap_next = padsnap_reg;
        case (state_reg)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    ir_next    = mem_in;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                link_next    = 16'(pc_ins);
                padsnap_next = pad_arr[ir_reg[3:0]];
                if (ir_reg == 16'd0) begin
                    state_next = S_STOP;
                end else if (ir_reg[15:12] != 4'b0100) begin
                    state_next = S_EXEC;
                end else begin
                    case (ir_reg[7:4])
                        4'b0000: state_next = S_LOAD;
                        4'b0100: state_next = S_STORE;
                        4'b1000: state_next = S_JAL_JMP;
                        4'b1100: state_next = S_JUMP;
                        4'b1111: state_next = S_PAD_LO;
                        default: state_next = S_FETCH;
                    endcase
                end
            end
            S_EXEC:    state_next = S_FETCH;
            S_LOAD:    if (mem_ready) state_next = S_LOAD_WB;
            S_LOAD_WB: state_next = S_FETCH;
            S_STORE:   if (mem_ready) state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            S_JAL_JMP: state_next = S_JAL_LO;
            S_JAL_LO:  state_next = S_JAL_HI;
            S_JAL_HI:  state_next = S_FETCH;
            S_PAD_LO:  state_next = S_PAD_HI;
            S_PAD_HI:  state_next = S_FETCH;
            S_STOP: begin
`ifdef CTRL_RESUME_EN
                if (resume) state_next = S_FETCH;
`endif
            end
            default:   state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_RESET;
            ir_reg      <= 16'd0;
            link_reg    <= 16'd0;
            padsnap_reg <= 12'd0;
        end else begin
            state_reg   <= state_next;
            ir_reg      <= ir_next;
            link_reg    <= link_next;
            padsnap_reg <= padsnap_next;
        end
    end

    always_comb begin
        opcode    = 16'd0;
        reg_en    = 16'd0;
        mux_a_sel = 4'd0;
        mux_b_sel = 4'd0;
        alu_sel   = 1'b1;
        pc_sel    = 1'b1;
        mem_req   = 1'b0;
        mem_w_en  = 1'b0;
        flag_en   = 1'b0;
        pc_en     = 1'b0;
        pc_ld     = 1'b0;
        halted    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                pc_en   = mem_ready;
            end
            S_EXEC: begin
                opcode    = ir_reg;
                mux_a_sel = ir_reg[11:8];
                mux_b_sel = ir_reg[3:0];
                flag_en   = 1'b1;
                // Compares only update flags.
                if (!((ir_reg[15:12] == 4'b0000 && ir_reg[7:4] == 4'b1011) ||
                      ir_reg[15:12] == 4'b1011))
                    reg_en = onehot(ir_reg[11:8]);
            end
            S_LOAD: begin
                mem_req   = 1'b1;
                pc_sel    = 1'b0;
                mux_a_sel = ir_reg[3:0];
            end
            S_LOAD_WB: begin
                alu_sel = 1'b0;
                reg_en  = onehot(ir_reg[11:8]);
            end
            S_STORE: begin
                mem_req   = 1'b1;
                mem_w_en  = 1'b1;
                pc_sel    = 1'b0;
                mux_a_sel = ir_reg[3:0];
                mux_b_sel = ir_reg[11:8];
            end
            S_JUMP: begin
                mux_a_sel = ir_reg[3:0];
                pc_ld     = cond_true(ir_reg[11:8], flags);
                pc_en     = cond_true(ir_reg[11:8], flags);
            end
            S_JAL_JMP: begin
                mux_a_sel = ir_reg[3:0];
                pc_ld     = 1'b1;
                pc_en     = 1'b1;
            end
            S_JAL_LO: begin
                opcode = {4'b1101, ir_reg[11:8], link_reg[7:0]};
                reg_en = onehot(ir_reg[11:8]);
            end
            S_JAL_HI: begin
                opcode = {4'b1111, ir_reg[11:8], link_reg[15:8]};
                reg_en = onehot(ir_reg[11:8]);
            end
            S_PAD_LO: begin
                opcode = {4'b1101, ir_reg[11:8], padsnap_reg[7:0]};
                reg_en = onehot(ir_reg[11:8]);
            end
            S_PAD_HI: begin
                opcode = {4'b1111, ir_reg[11:8], 4'b0000, padsnap_reg[11:8]};
                reg_en = onehot(ir_reg[11:8]);
            end
            S_STOP:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed self-checking bench for cpu_ctrl_fsm (ADDR_WIDTH=12, PAD_COUNT=2).
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_in;
    logic        mem_ready;
    logic [4:0]  flags;
    logic [11:0] pc_ins;
    logic [23:0] pad_data;
    logic        resume;
    logic [15:0] opcode, reg_en;
    logic [3:0]  mux_a_sel, mux_b_sel;
    logic        alu_sel, pc_sel, mem_req, mem_w_en, flag_en, pc_en, pc_ld, halted;

    int tests = 0;
    int fails = 0;

    cpu_ctrl_fsm #(.ADDR_WIDTH(12), .PAD_COUNT(2)) dut (
        .clk(clk), .reset(reset), .mem_in(mem_in), .mem_ready(mem_ready),
        .flags(flags), .pc_ins(pc_ins), .pad_data(pad_data), .resume(resume),
        .opcode(opcode), .reg_en(reg_en), .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel),
        .alu_sel(alu_sel), .pc_sel(pc_sel), .mem_req(mem_req), .mem_w_en(mem_w_en),
        .flag_en(flag_en), .pc_en(pc_en), .pc_ld(pc_ld), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a word in FETCH with ready high, then step through DECODE.
    task automatic fetch_word(input logic [15:0] w);
        mem_in    = w;
        mem_ready = 1'b1;
        #1;
        check("fetch_pc_en", 16'(pc_en), 16'd1);
        tick();
        check("decode_pc_en", 16'(pc_en), 16'd0);
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        mem_in    = 16'd0;
        mem_ready = 1'b1;
        flags     = 5'd0;
        pc_ins    = 12'd0;
        pad_data  = {12'hABC, 12'h123};
        resume    = 1'b0;

        tick();
        check("rst_mem_req", 16'(mem_req), 16'd0);
        check("rst_alu_sel", 16'(alu_sel), 16'd1);
        check("rst_pc_sel", 16'(pc_sel), 16'd1);
        check("rst_opcode", opcode, 16'd0);
        check("rst_reg_en", reg_en, 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        reset = 1'b1;
        tick();
        check("first_fetch_req", 16'(mem_req), 16'd1);
        $display("[TB] reset released, in FETCH");

        // R-type ADD then CMP
        fetch_word(16'h0355);
        check("add_opcode", opcode, 16'h0355);
        check("add_reg_en", reg_en, 16'h0008);
        check("add_flag_en", 16'(flag_en), 16'd1);
        check("add_mux", {8'd0, mux_a_sel, mux_b_sel}, 16'h0035);
        tick();
        fetch_word(16'h03B5);
        check("cmp_reg_en", reg_en, 16'h0000);
        check("cmp_flag_en", 16'(flag_en), 16'd1);
        tick();
        $display("[TB] ADD/CMP done");

        // Load with three wait cycles
        fetch_word(16'h4201);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("load_wait_req", 16'(mem_req), 16'd1);
            check("load_wait_pcsel", 16'(pc_sel), 16'd0);
            check("load_wait_muxa", 16'(mux_a_sel), 16'd1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("load_ready_req", 16'(mem_req), 16'd1);
        tick();
        check("loadwb_alu_sel", 16'(alu_sel), 16'd0);
        check("loadwb_reg_en", reg_en, 16'h0004);
        check("loadwb_mem_req", 16'(mem_req), 16'd0);
        tick();
        $display("[TB] load with wait states done");

        // Reset asserted mid-LOAD with memory stalled
        fetch_word(16'h4201);
        mem_ready = 1'b0;
        reset = 1'b0;
        tick();
        check("midrst_mem_req", 16'(mem_req), 16'd0);
        check("midrst_reg_en", reg_en, 16'd0);
        check("midrst_alu_sel", 16'(alu_sel), 16'd1);
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("midrst_still_idle", 16'(mem_req), 16'd0);
        tick();
        check("midrst_fetch", 16'(mem_req), 16'd1);
        $display("[TB] mid-load reset done");

        // Conditional jumps
        flags = 5'b10000;
        fetch_word(16'h40C4);
        check("jeq_taken_ld", 16'(pc_ld), 16'd1);
        check("jeq_taken_en", 16'(pc_en), 16'd1);
        check("jeq_muxa", 16'(mux_a_sel), 16'd4);
        tick();
        flags = 5'b00000;
        fetch_word(16'h40C4);
        check("jeq_not_ld", 16'(pc_ld), 16'd0);
        check("jeq_not_en", 16'(pc_en), 16'd0);
        tick();
        flags = 5'b11111;
        fetch_word(16'h4FC4);
        check("jnever_ld", 16'(pc_ld), 16'd0);
        tick();
        flags = 5'b00000;
        fetch_word(16'h4AC4);
        check("j_nl_nz_ld", 16'(pc_ld), 16'd1);
        tick();
        $display("[TB] jumps done");

        // Store held while memory stalls
        fetch_word(16'h4742);
        mem_ready = 1'b0;
        #1;
        check("store_wen", 16'(mem_w_en), 16'd1);
        check("store_mux", {8'd0, mux_a_sel, mux_b_sel}, 16'h0027);
        tick();
        check("store_hold_wen", 16'(mem_w_en), 16'd1);
        check("store_hold_pcsel", 16'(pc_sel), 16'd0);
        mem_ready = 1'b1;
        tick();
        check("after_store_wen", 16'(mem_w_en), 16'd0);
        check("after_store_req", 16'(mem_req), 16'd1);
        $display("[TB] store done");

        // JAL r2 <- r2 with pc_ins snapshot
        pc_ins = 12'h345;
        fetch_word(16'h4282);
        pc_ins = 12'h999;
        check("jal_pc_ld", 16'(pc_ld), 16'd1);
        check("jal_muxa", 16'(mux_a_sel), 16'd2);
        tick();
        check("jal_lo_opcode", opcode, 16'hD245);
        check("jal_lo_reg_en", reg_en, 16'h0004);
        check("jal_lo_flag_en", 16'(flag_en), 16'd0);
        tick();
        check("jal_hi_opcode", opcode, 16'hF203);
        tick();
        $display("[TB] JAL done");

        // Pad reads, snapshot taken in DECODE
        fetch_word(16'h46F1);
        pad_data = 24'h000000;
        check("pad1_lo", opcode, 16'hD6BC);
        check("pad1_reg_en", reg_en, 16'h0040);
        tick();
        check("pad1_hi", opcode, 16'hF60A);
        tick();
        fetch_word(16'h46F5);
        check("pad5_lo", opcode, 16'hD600);
        tick();
        check("pad5_hi", opcode, 16'hF600);
        tick();
        pad_data = {12'hABC, 12'h123};
        fetch_word(16'h46F0);
        check("pad0_lo", opcode, 16'hD623);
        tick();
        check("pad0_hi", opcode, 16'hF601);
        tick();
        $display("[TB] pad reads done");

        // Unknown sub-op behaves as no-op
        fetch_word(16'h4210);
        check("nop_fetch_req", 16'(mem_req), 16'd1);
        check("nop_reg_en", reg_en, 16'd0);
        $display("[TB] unknown sub-op done");

        // Halt and optional resume
        fetch_word(16'h0000);
        check("stop_halted", 16'(halted), 16'd1);
        check("stop_mem_req", 16'(mem_req), 16'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
`ifdef CTRL_RESUME_EN
        check("resume_halted", 16'(halted), 16'd0);
        check("resume_fetch", 16'(mem_req), 16'd1);
`else
        check("noresume_halted", 16'(halted), 16'd1);
        check("noresume_req", 16'(mem_req), 16'd0);
`endif
        $display("[TB] halt done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
